// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// mole_pkg : shared types and constants for the whack-a-mole game core
// Revision : 1.0
// ============================================================================
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        OVER = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// ============================================================================
// bcd_score_counter : two-digit BCD counter, saturating at 99, clear over inc
// Revision : 1.0
// ============================================================================
module bcd_score_counter
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic at_max;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        at_max = (tens_q == 4'd9) && (ones_q == 4'd9);
        if (clear) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc && !at_max) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule
`default_nettype wire

// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// mole_game_ctrl : lights pseudo-random moles, scores rising-edge hits in BCD
// Revision : 1.0
// ============================================================================
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int          N_MOLES    = 8,
    parameter int          MOLE_TICKS = 50_000_000,
    parameter int          GAP_TICKS  = 12_500_000,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               time_up,
    input  logic [N_MOLES-1:0] btn,
    output logic [N_MOLES-1:0] led,
    output logic [3:0]         score_tens,
    output logic [3:0]         score_ones,
    output logic               playing,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam int IDX_W     = $clog2(N_MOLES);
    localparam int MAX_TICKS = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0]   MOLE_LOAD = CNT_W'(MOLE_TICKS - 1);
    localparam logic [N_MOLES-1:0] LED_ONE   = {{(N_MOLES-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [IDX_W-1:0]   prev_idx_q, prev_idx_d;
    logic [N_MOLES-1:0] btn_q;
    logic [N_MOLES-1:0] led_q, led_d;
    logic               playing_q, playing_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;

    logic               score_clear;
    logic               score_inc;
    logic [N_MOLES-1:0] rise;
    logic               lit_rise;
    logic               stray_rise;
    logic [IDX_W-1:0]   raw_idx;
    logic [IDX_W-1:0]   next_idx;

    always_comb begin
        rise       = btn & ~btn_q;
        lit_rise   = |(rise & led_q);
        stray_rise = |(rise & ~led_q);
        raw_idx    = lfsr_q[IDX_W-1:0];
        // never light the same mole twice in a row
        next_idx   = (raw_idx == prev_idx_q) ? raw_idx + IDX_W'(1) : raw_idx;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        led_d       = led_q;
        prev_idx_d  = prev_idx_q;
        lfsr_d      = lfsr_step(lfsr_q);
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        score_clear = 1'b0;
        score_inc   = 1'b0;

        if (start) begin
            state_d     = GAP;
            cnt_d       = GAP_LOAD;
            led_d       = '0;
            score_clear = 1'b1;
        end else begin
            case (state_q)
                GAP: begin
                    if (time_up) begin
                        state_d = OVER;
                        led_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d    = UP;
                        cnt_d      = MOLE_LOAD;
                        led_d      = LED_ONE << next_idx;
                        prev_idx_d = next_idx;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                UP: begin
                    if (time_up) begin
                        state_d = OVER;
                        led_d   = '0;
                    end else if (lit_rise) begin
                        state_d   = GAP;
                        cnt_d     = GAP_LOAD;
                        led_d     = '0;
                        hit_d     = 1'b1;
                        score_inc = 1'b1;
                    end else begin
                        // a stray press does not extend the mole window
                        miss_d = stray_rise;
                        if (cnt_q == '0) begin
                            state_d = GAP;
                            cnt_d   = GAP_LOAD;
                            led_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    led_d = '0;
                end
            endcase
        end

        playing_d = (state_d == GAP) || (state_d == UP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            prev_idx_q <= '0;
            btn_q      <= '0;
            led_q      <= '0;
            playing_q  <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            prev_idx_q <= prev_idx_d;
            btn_q      <= btn;
            led_q      <= led_d;
            playing_q  <= playing_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    bcd_score_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (score_inc),
        .tens  (score_tens),
        .ones  (score_ones)
    );

    assign led        = led_q;
    assign playing    = playing_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mole_game_ctrl : directed self-checking bench for mole_game_ctrl
// Revision : 1.0
// ============================================================================
module tb_mole_game_ctrl;

    localparam int N  = 8;
    localparam int MT = 10;
    localparam int GT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         time_up;
    logic [N-1:0] btn;
    logic [N-1:0] led;
    logic [3:0]   score_tens;
    logic [3:0]   score_ones;
    logic         playing;
    logic         hit_pulse;
    logic         miss_pulse;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           m_prev;
    int           m_score;
    logic [N-1:0] m_led;
    logic [N-1:0] last_led;
    logic         have_last;
    logic [15:0]  m_lfsr;

    always #5 clk = ~clk;

    mole_game_ctrl #(
        .N_MOLES    (N),
        .MOLE_TICKS (MT),
        .GAP_TICKS  (GT),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .time_up    (time_up),
        .btn        (btn),
        .led        (led),
        .score_tens (score_tens),
        .score_ones (score_ones),
        .playing    (playing),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse)
    );

    // reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Galois
    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) begin
            r[15] = ~r[15];
            r[13] = ~r[13];
            r[12] = ~r[12];
            r[10] = ~r[10];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m_lfsr <= reset ? 16'hACE1 : ref_lfsr_next(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called on the negedge right after the edge that entered GAP.
    task automatic gap_to_up();
        int idx;
        for (int i = 0; i < GT; i++) begin
            chk("gap_led_off", led, 0);
            chk("gap_playing", playing, 1);
            if (i == 1) begin
                chk("pulse_hit_low", hit_pulse, 0);
                chk("pulse_miss_low", miss_pulse, 0);
            end
            if (i < GT - 1) tick();
        end
        idx = int'(m_lfsr[2:0]);
        if (idx == m_prev) idx = (idx + 1) % N;
        tick();
        m_led = 8'b0000_0001 << idx;
        chk("mole_led", led, m_led);
        if (have_last) chk("mole_repeat", (led == last_led), 0);
        last_led  = led;
        have_last = 1'b1;
        m_prev    = idx;
    endtask

    task automatic hit();
        btn = m_led;
        tick();
        btn = '0;
        if (m_score < 99) m_score++;
        chk("hit_pulse", hit_pulse, 1);
        chk("hit_miss", miss_pulse, 0);
        chk("hit_led_off", led, 0);
        chk("hit_tens", score_tens, m_score / 10);
        chk("hit_ones", score_ones, m_score % 10);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_led"}, led, 0);
        chk({tag, "_tens"}, score_tens, 0);
        chk({tag, "_ones"}, score_ones, 0);
        chk({tag, "_playing"}, playing, 0);
        chk({tag, "_hit"}, hit_pulse, 0);
        chk({tag, "_miss"}, miss_pulse, 0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        time_up = 1'b0;
        btn     = '0;
        m_prev  = 0;
        m_score = 0;
        m_led   = '0;
        last_led  = '0;
        have_last = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();
        tick();
        chk("idle_playing", playing, 0);

        // start, first mole, ten hits
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_playing", playing, 1);
        gap_to_up();
        for (int h = 0; h < 10; h++) begin
            hit();
            gap_to_up();
        end
        chk("ten_tens", score_tens, 1);
        chk("ten_ones", score_ones, 0);

        // wrong button then the right one
        btn = 8'b0000_0001 << ((m_prev + 3) % N);
        tick();
        btn = '0;
        chk("miss_pulse", miss_pulse, 1);
        chk("miss_hit", hit_pulse, 0);
        chk("miss_led", led, m_led);
        chk("miss_ones", score_ones, m_score % 10);
        tick();
        chk("miss_pulse_low", miss_pulse, 0);
        chk("miss_led_kept", led, m_led);
        hit();
        gap_to_up();

        // no press: mole times out after MT cycles
        for (int i = 1; i < MT; i++) begin
            tick();
            chk("timeout_led_on", led, m_led);
        end
        tick();
        chk("timeout_led_off", led, 0);
        chk("timeout_hit", hit_pulse, 0);
        chk("timeout_miss", miss_pulse, 0);
        chk("timeout_ones", score_ones, m_score % 10);
        gap_to_up();

        // button held across GAP->UP gives no rise
        hit();
        btn = '1;
        gap_to_up();
        tick();
        chk("held_hit", hit_pulse, 0);
        chk("held_miss", miss_pulse, 0);
        chk("held_ones", score_ones, m_score % 10);
        btn = '0;
        tick();
        chk("held_release_hit", hit_pulse, 0);
        hit();
        gap_to_up();

        // time_up wins over a simultaneous correct rise
        btn     = m_led;
        time_up = 1'b1;
        tick();
        btn = '0;
        chk("over_led", led, 0);
        chk("over_playing", playing, 0);
        chk("over_hit", hit_pulse, 0);
        chk("over_tens", score_tens, m_score / 10);
        chk("over_ones", score_ones, m_score % 10);
        tick();
        chk("over_stays", playing, 0);
        chk("over_held_ones", score_ones, m_score % 10);
        start = 1'b1;
        tick();
        start   = 1'b0;
        time_up = 1'b0;
        m_score = 0;
        chk("restart_tens", score_tens, 0);
        chk("restart_ones", score_ones, 0);
        chk("restart_playing", playing, 1);
        gap_to_up();

        // 100 hits: saturate at 99 while hit_pulse keeps firing
        for (int h = 0; h < 100; h++) begin
            hit();
            gap_to_up();
        end
        chk("sat_tens", score_tens, 9);
        chk("sat_ones", score_ones, 9);

        // reset in the middle of UP
        reset = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        reset     = 1'b0;
        m_prev    = 0;
        m_score   = 0;
        have_last = 1'b0;
        tick();
        chk("midreset_idle", playing, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        gap_to_up();
        hit();
        chk("post_reset_ones", score_ones, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
